// File: rtl/imem_loader.sv
// imem_loader: boot loader that packs a byte stream into 32-bit instruction words,
// writes them to sequential instruction-memory addresses, verifies a trailing
// checksum byte and only then releases the CPU reset.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_start, i_word_count begin a load of i_word_count words (IDLE/RUN/FAIL only)
//   i_byte_valid/o_byte_ready, i_byte_data  byte stream handshake
//   o_imem_we, o_imem_addr, o_imem_wdata    one-cycle word write to instruction memory
//   o_cpu_rst             CPU reset, low only in RUN
//   o_busy, o_done, o_err load in progress, success pulse, sticky failure
module imem_loader #(
    parameter int ADDR_WIDTH = 6,
    parameter int DEPTH      = 64
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH:0]   i_word_count,
    input  logic                  i_byte_valid,
    input  logic [7:0]            i_byte_data,
    output logic                  o_byte_ready,
    output logic                  o_imem_we,
    output logic [ADDR_WIDTH-1:0] o_imem_addr,
    output logic [31:0]           o_imem_wdata,
    output logic                  o_cpu_rst,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CHECK, S_RUN, S_FAIL} state_t;
    localparam logic [ADDR_WIDTH:0] L_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
    state_t                r_state, w_state_n;
    logic [ADDR_WIDTH:0]   r_cnt, r_widx;
    logic [1:0]            r_idx;
    logic [31:0]           r_buf;
    logic [7:0]            r_sum, w_sum;
    logic                  r_we, r_done;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [31:0]           r_wdata;
    logic                  w_acc, w_go, w_last;
    // Status outputs decode the state register directly, so they stay registered.
    assign o_byte_ready = r_state == S_LOAD || r_state == S_CHECK;
    assign o_busy       = o_byte_ready;
    assign o_cpu_rst    = r_state != S_RUN;
    assign o_err        = r_state == S_FAIL;
    assign o_imem_we    = r_we;
    assign o_imem_addr  = r_waddr;
    assign o_imem_wdata = r_wdata;
    assign o_done       = r_done;
    assign w_acc  = i_byte_valid && o_byte_ready;
    assign w_go   = i_start && (r_state == S_IDLE || r_state == S_RUN || r_state == S_FAIL);
    assign w_sum  = r_sum + i_byte_data;
    assign w_last = r_idx == 2'd3 && r_widx + 1'b1 == r_cnt;
    always_comb begin
        w_state_n = r_state;
        if (w_go)
            w_state_n = i_word_count == '0 ? S_CHECK : i_word_count > L_DEPTH ? S_FAIL : S_LOAD;
        else if (w_acc && r_state == S_LOAD && w_last)
            w_state_n = S_CHECK;
        else if (w_acc && r_state == S_CHECK)
            w_state_n = w_sum == 8'd0 ? S_RUN : S_FAIL;
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_n;
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt   <= '0;
            r_widx  <= '0;
            r_idx   <= '0;
            r_buf   <= '0;
            r_sum   <= '0;
            r_we    <= 1'b0;
            r_done  <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_we   <= 1'b0;
            r_done <= 1'b0;
            if (w_go) begin
                r_cnt  <= i_word_count;
                r_widx <= '0;
                r_idx  <= '0;
                r_sum  <= '0;
            end else if (w_acc) begin
                r_sum <= w_sum;
                if (r_state == S_CHECK) begin
                    r_done <= w_sum == 8'd0;
                end else begin
                    r_idx <= r_idx + 1'b1;
                    r_buf[{r_idx, 3'b000} +: 8] <= i_byte_data;
                    // Index-3 byte goes straight into the write word, bypassing r_buf.
                    if (r_idx == 2'd3) begin
                        r_we    <= 1'b1;
                        r_waddr <= r_widx[ADDR_WIDTH-1:0];
                        r_wdata <= {i_byte_data, r_buf[23:0]};
                        r_widx  <= r_widx + 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that sits upstream of the pipelined CPU's instruction memory. It accepts a byte stream over a valid/ready handshake and packs every four bytes into a little-endian 32-bit word. Each word is written to sequential instruction-memory addresses. After a trailing checksum byte is verified, it releases the CPU's reset, so the core only starts fetching once a complete, verified program image is in memory.

## Interface
- ADDR_WIDTH, 6: instruction-memory word-address width.
- DEPTH, 64: number of instruction-memory words; must be ≤ 2^ADDR_WIDTH.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  begin a load; sampled in IDLE, RUN and FAIL only.
- word_count  in  ADDR_WIDTH+1  number of program words; sampled on the accepted start.
- byte_valid  in  1  byte_data is valid.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader can accept a byte.
- imem_we  out  1  instruction-memory write strobe, one cycle per word.
- imem_addr  out  ADDR_WIDTH  word address for the write.
- imem_wdata  out  32  word to write.
- cpu_rst  out  1  reset to the CPU, active-high.
- busy  out  1  high in LOAD and CHECK.
- done  out  1  one-cycle pulse when a load completes successfully.
- err  out  1  sticky high in FAIL.

## Operation
- States:
  - IDLE: after reset; cpu_rst=1.
  - LOAD: receiving word bytes.
  - CHECK: waiting for the checksum byte.
  - RUN: CPU released.
  - FAIL: image rejected; cpu_rst=1.
- Handshake: a byte is accepted when byte_valid && byte_ready. byte_ready=1 only in LOAD and CHECK. byte_data is ignored when not accepted.
- Accepted start in IDLE, RUN or FAIL:
  - Latches word_count.
  - Clears the byte index, word address, running sum and err.
  - Asserts cpu_rst.
  - Goes to LOAD, or to CHECK if word_count==0, or to FAIL if word_count>DEPTH.
- start is ignored in LOAD and CHECK.
- Byte packing is little-endian: byte index 0→[7:0], 1→[15:8], 2→[23:16], 3→[31:24].
- The accepted byte on index 3 completes the word:
  - The word is registered to imem_wdata and the current address to imem_addr.
  - The address increments.
  - On the last word, the state moves to CHECK.
- Running sum: 8-bit, modulo 256, over every accepted data byte.
- In CHECK, one byte is accepted. If (sum + byte) mod 256 == 0, go to RUN; otherwise go to FAIL.
- RUN: cpu_rst=0; stays there until start or rst.
- FAIL: err=1, cpu_rst=1; stays there until start or rst.
- rst in any state, including mid-word or mid-load:
  - Returns to IDLE.
  - Discards any partial word.
  - Issues no write.

## Timing
- Reset values: byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst=1, busy=0, done=0, err=0.
- All outputs are registered.
- Write latency: imem_we is high exactly one cycle, the cycle after the index-3 byte handshake. imem_addr and imem_wdata are valid in that same cycle.
- Bytes may arrive back-to-back, one per cycle, with no bubbles required. A write may overlap the next byte's acceptance.
- Checksum latency: the cycle after the checksum handshake, cpu_rst falls to 0 and done=1 for that one cycle (pass), or err rises to 1 (fail).
- byte_ready drops the cycle after the checksum handshake.
- Restart: start accepted in RUN gives cpu_rst=1 and busy=1 on the next cycle.
- Address wrap: the address never exceeds word_count-1 ≤ DEPTH-1, so it cannot wrap.
- Simultaneous start with rst: rst wins; the state is IDLE.

## Test plan
- Nominal load: word_count=2, bytes 93 00 50 00 13 81 10 00 then checksum 79, back-to-back. Required:
  - imem_we at addr 0 with 0x00500093.
  - imem_we at addr 1 with 0x00108113.
  - Then cpu_rst=0 and one done pulse, with err=0.
- Bad checksum: same stream with checksum 7A. Required: both writes occur, then err=1, cpu_rst stays 1, no done pulse.
- Stalled source: same nominal stream with byte_valid low for 3 cycles between every byte. Required: identical writes and result, with no write issued early.
- Reset mid-load: assert rst after 6 data bytes. Required:
  - Only the addr-0 write occurs.
  - All outputs return to reset values.
  - A new nominal load then succeeds from addr 0.
- Boundary counts:
  - word_count=0, checksum 00: RUN with no writes.
  - word_count=65 with DEPTH=64: FAIL immediately, byte_ready stays 0.
- Restart: start in RUN with a new 1-word image 13 00 00 00, checksum ED. Required: cpu_rst=1 during the load, write of 0x00000013 to addr 0, then RUN again.
